// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM pipeline types for the MEM stage SRAM path
package arm_pkg;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} mem_state_t;
  typedef enum logic {RD, WR} mem_op_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_addr_map.sv
// rtl/sram_addr_map.sv - maps an ARM byte address plus half select onto a 16-bit SRAM word address
module sram_addr_map
  import arm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          SRAM_AW   = 18
) (
  input  logic [31:0]        alu_result,
  input  logic               half,
  output logic [SRAM_AW-1:0] sram_addr
);

  logic [31:0] off;
  logic        unused_off;

  // Addresses below BASE_ADDR wrap; byte offset within the word is ignored.
  assign off        = alu_result - BASE_ADDR;
  assign sram_addr  = {off[SRAM_AW:2], half};
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM stage: 32-bit loads/stores as two half-word accesses on a 16-bit SRAM
module mem_stage_sram_ctrl
  import arm_pkg::*;
#(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int          SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        val_rm,
  output logic [31:0]        mem_result,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 1);

  mem_state_t         state, next_state;
  mem_op_t            op;
  logic [2:0]         wait_cnt, next_cnt;
  logic [31:0]        addr_lat, data_lat;
  logic [15:0]        lo_reg, hi_reg;
  logic               req, last, next_half, next_access;
  logic [31:0]        addr_src, data_src;
  logic [SRAM_AW-1:0] map_addr;

  assign req         = mem_r_en | mem_w_en;
  assign last        = (wait_cnt == LAST_CNT);
  assign next_half   = (next_state == HI);
  assign next_access = (next_state == LO) || (next_state == HI);

  // Entering LO from IDLE uses the live inputs, since the latches load on that same edge.
  assign addr_src = (state == IDLE) ? alu_result : addr_lat;
  assign data_src = (state == IDLE) ? val_rm : data_lat;

  sram_addr_map #(
    .BASE_ADDR (BASE_ADDR),
    .SRAM_AW   (SRAM_AW)
  ) u_addr_map (
    .alu_result (addr_src),
    .half       (next_half),
    .sram_addr  (map_addr)
  );

  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    ready      = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          next_state = LO;
          next_cnt   = '0;
        end
      end
      LO, HI: begin
        sram_we_n  = (op != WR);
        sram_oe_n  = (op != RD);
        sram_dq_oe = (op == WR);
        if (last) begin
          next_cnt   = '0;
          next_state = (state == LO) ? HI : DONE;
        end else begin
          next_cnt = wait_cnt + 3'd1;
        end
      end
      DONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op          <= RD;
      wait_cnt    <= '0;
      addr_lat    <= '0;
      data_lat    <= '0;
      lo_reg      <= '0;
      hi_reg      <= '0;
      mem_result  <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      if (state == IDLE && req) begin
        addr_lat <= alu_result;
        data_lat <= val_rm;
        op       <= mem_w_en ? WR : RD;
      end
      if (next_access) begin
        sram_addr   <= map_addr;
        sram_dq_out <= next_half ? data_src[31:16] : data_src[15:0];
      end
      if (state == LO && last && op == RD) begin
        lo_reg <= sram_dq_in;
      end
      // The high half lands in hi_reg and mem_result on the same edge that enters DONE.
      if (state == HI && last && op == RD) begin
        hi_reg     <= sram_dq_in;
        mem_result <= {sram_dq_in, lo_reg};
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - scoreboard bench for mem_stage_sram_ctrl at ACCESS_CYCLES 2 and 1
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        mem_r_en, mem_w_en, ready, sram_dq_oe, sram_we_n, sram_oe_n;
  logic [31:0] alu_result, val_rm, mem_result;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic [15:0] mem_a [0:63];

  logic        r1, w1, ready_1, dq_oe_1, we_n_1, oe_n_1;
  logic [31:0] alu_1, val_1, result_1;
  logic [17:0] addr_1;
  logic [15:0] dq_out_1, dq_in_1;
  logic [15:0] mem_b [0:63];

  mem_stage_sram_ctrl u_dut (
    .clk (clk), .rst (rst), .mem_r_en (mem_r_en), .mem_w_en (mem_w_en),
    .alu_result (alu_result), .val_rm (val_rm), .mem_result (mem_result), .ready (ready),
    .sram_addr (sram_addr), .sram_dq_out (sram_dq_out), .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in), .sram_we_n (sram_we_n), .sram_oe_n (sram_oe_n)
  );

  mem_stage_sram_ctrl #(.ACCESS_CYCLES(1)) u_dut1 (
    .clk (clk), .rst (rst), .mem_r_en (r1), .mem_w_en (w1),
    .alu_result (alu_1), .val_rm (val_1), .mem_result (result_1), .ready (ready_1),
    .sram_addr (addr_1), .sram_dq_out (dq_out_1), .sram_dq_oe (dq_oe_1),
    .sram_dq_in (dq_in_1), .sram_we_n (we_n_1), .sram_oe_n (oe_n_1)
  );

  assign sram_dq_in = mem_a[sram_addr[5:0]];
  assign dq_in_1    = mem_b[addr_1[5:0]];
  always @(posedge clk) if (!sram_we_n) mem_a[sram_addr[5:0]] <= sram_dq_out;
  always @(posedge clk) if (!we_n_1) mem_b[addr_1[5:0]] <= dq_out_1;

  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Counts strobe cycles from the request cycle (cycle 0) until ready rises, then scores mem_result.
  task automatic wait_done(input string tag, input logic rd, input logic wr);
    int cyc, we_low, oe_low, dqoe;
    logic [31:0] exp;
    we_low = 0; oe_low = 0; dqoe = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (sram_dq_oe) dqoe++;
      if (ready) break;
    end
    check({tag, " latency"}, cyc, 5);
    check({tag, " we_n low cycles"}, we_low, wr ? 4 : 0);
    check({tag, " oe_n low cycles"}, oe_low, (rd && !wr) ? 4 : 0);
    check({tag, " dq_oe cycles"}, dqoe, wr ? 4 : 0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
    check({tag, " mem_result"}, mem_result, exp);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data, input logic [31:0] exp_res);
    @(negedge clk);
    mem_r_en = rd; mem_w_en = wr; alu_result = addr; val_rm = data;
    exp_q.push_back(exp_res);
    wait_done(tag, rd, wr);
  endtask

  task automatic run_op1(input string tag, input logic rd, input logic wr,
                         input logic [31:0] data, input logic [31:0] exp_res);
    int cyc, strobe;
    @(negedge clk);
    r1 = rd; w1 = wr; alu_1 = 32'd1024; val_1 = data;
    exp_q.push_back(exp_res);
    strobe = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (!we_n_1 || !oe_n_1) strobe++;
      if (ready_1) break;
    end
    check({tag, " latency"}, cyc, 3);
    check({tag, " strobe cycles"}, strobe, 2);
    check({tag, " mem_result"}, result_1, exp_q.pop_front());
    r1 = 1'b0; w1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_r_en = 0; mem_w_en = 0; alu_result = 0; val_rm = 0;
    r1 = 0; w1 = 0; alu_1 = 0; val_1 = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst ready", ready, 1);
    check("rst we_n", sram_we_n, 1);
    check("rst oe_n", sram_oe_n, 1);
    check("rst dq_oe", sram_dq_oe, 0);
    check("rst mem_result", mem_result, 0);
    check("rst sram_addr", sram_addr, 0);
    check("rst dq_out", sram_dq_out, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("idle ready", ready, 1);
      check("idle strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
    end

    run_op("store 1024", 0, 1, 32'd1024, 32'hDEADBEEF, 32'h0);
    check("sram[0]", mem_a[0], 16'hBEEF);
    check("sram[1]", mem_a[1], 16'hDEAD);
    run_op("load 1024", 1, 0, 32'd1024, 32'h0, 32'hDEADBEEF);
    run_op("store 1028", 0, 1, 32'd1028, 32'h12345678, 32'hDEADBEEF);
    check("sram[2]", mem_a[2], 16'h5678);
    check("sram[3]", mem_a[3], 16'h1234);
    run_op("store 1031", 0, 1, 32'd1031, 32'hCAFEF00D, 32'hDEADBEEF);
    check("sram[2] unaligned", mem_a[2], 16'hF00D);
    check("sram[3] unaligned", mem_a[3], 16'hCAFE);
    run_op("both en 1032", 1, 1, 32'd1032, 32'hA5A55A5A, 32'hDEADBEEF);
    check("sram[4]", mem_a[4], 16'h5A5A);
    check("sram[5]", mem_a[5], 16'hA5A5);
    run_op("store 1020 wrap", 0, 1, 32'd1020, 32'h01020304, 32'hDEADBEEF);
    check("wrap sram_addr", sram_addr, 18'h3FFFF);
    check("sram[62]", mem_a[62], 16'h0304);
    check("sram[63]", mem_a[63], 16'h0102);
    run_op("load 1028", 1, 0, 32'd1028, 32'h0, 32'hCAFEF00D);

    @(negedge clk);
    mem_r_en = 1'b1; alu_result = 32'd1024;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("midrst mem_result", mem_result, 0);
    check("midrst strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
    check("midrst ready", ready, 0);
    rst = 1'b0;
    wait_done("restart load", 1, 0);

    run_op1("ac1 store", 0, 1, 32'h22221111, 32'h0);
    check("ac1 sram[0]", mem_b[0], 16'h1111);
    check("ac1 sram[1]", mem_b[1], 16'h2222);
    run_op1("ac1 load", 1, 0, 32'h0, 32'h22221111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
